// File: rtl/temp_read_sequencer_pkg.sv
// temp_read_sequencer_pkg: shared state encoding, data widths and helpers for the I2C temperature blocks
package temp_read_sequencer_pkg;

  localparam int TEMP_W = 12;
  localparam int BYTE_W = 8;
  localparam int DEG_W  = 8;
  localparam int FRAC_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_MSB,
    WAIT_LSB,
    PUBLISH,
    FAULT,
    WAIT_INTERVAL
  } state_t;

  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return (&v) ? v : v + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/temp_read_sequencer_converter.sv
// temp_code_converter: splits a 12-bit two's complement temperature into sign, whole degrees and sixteenths
module temp_code_converter
  import temp_read_sequencer_pkg::*;
(
  input  logic [TEMP_W-1:0] code_i,
  output logic              negative_o,
  output logic [DEG_W-1:0]  degrees_o,
  output logic [FRAC_W-1:0] fraction_o
);

  logic [TEMP_W-1:0] mag;

  // 0x800 negates to itself, which reads back as 128 whole degrees
  always_comb begin
    mag        = code_i[TEMP_W-1] ? (~code_i + TEMP_W'(1)) : code_i;
    negative_o = code_i[TEMP_W-1];
    degrees_o  = mag[TEMP_W-1:FRAC_W];
    fraction_o = mag[FRAC_W-1:0];
  end

endmodule

// File: rtl/temp_read_sequencer.sv
// temp_read_sequencer: periodically requests a two-byte temperature read over I2C and publishes the result
module temp_read_sequencer
  import temp_read_sequencer_pkg::*;
#(
  parameter int unsigned SampleInterval = 60000000,
  parameter int unsigned TimeoutCycles  = 120000
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Busy,
  input  logic              ByteReady,
  input  logic [BYTE_W-1:0] ReceivedData,
  output logic              Go,
  output logic [TEMP_W-1:0] Temperature,
  output logic              TempValid,
  output logic              Negative,
  output logic [DEG_W-1:0]  Degrees,
  output logic [FRAC_W-1:0] Fraction,
  output logic              Error,
  output logic [BYTE_W-1:0] ErrorCount
);

  localparam int unsigned IW = $clog2(SampleInterval + 1);
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [IW-1:0] INT_LAST = IW'(SampleInterval - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TimeoutCycles - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     int_q, int_d;
  logic [TW-1:0]     to_q, to_d;
  logic [BYTE_W-1:0] msb_q, msb_d;
  logic [BYTE_W-1:0] ecnt_q, ecnt_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              neg_q, neg_d;
  logic [DEG_W-1:0]  deg_q, deg_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [TEMP_W-1:0] code;
  logic              conv_neg;
  logic [DEG_W-1:0]  conv_deg;
  logic [FRAC_W-1:0] conv_frac;
  logic              expired;
  logic              lsb_low_unused;

  // only the upper nibble of the second byte carries temperature bits
  assign code           = {msb_q, ReceivedData[BYTE_W-1:BYTE_W-FRAC_W]};
  assign lsb_low_unused = ^ReceivedData[BYTE_W-FRAC_W-1:0];
  assign expired        = (to_q == TO_LAST);

  temp_code_converter u_conv (
    .code_i    (code),
    .negative_o(conv_neg),
    .degrees_o (conv_deg),
    .fraction_o(conv_frac)
  );

  // next-state, counters and capture; the interval counter saturates so a slow transaction never wraps it
  always_comb begin
    state_d = state_q;
    int_d   = (int_q == INT_LAST) ? int_q : int_q + IW'(1);
    to_d    = to_q;
    msb_d   = msb_q;
    ecnt_d  = ecnt_q;
    temp_d  = temp_q;
    neg_d   = neg_q;
    deg_d   = deg_q;
    frac_d  = frac_q;
    Go      = 1'b0;
    case (state_q)
      IDLE: state_d = Enable ? START : IDLE;
      START: begin
        if (!Busy) begin
          Go      = 1'b1;
          to_d    = '0;
          int_d   = IW'(1);
          state_d = WAIT_MSB;
        end
      end
      WAIT_MSB: begin
        if (ByteReady) begin
          msb_d   = ReceivedData;
          to_d    = '0;
          state_d = WAIT_LSB;
        end else if (expired) begin
          ecnt_d  = sat_inc(ecnt_q);
          state_d = FAULT;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      WAIT_LSB: begin
        if (ByteReady) begin
          temp_d  = code;
          neg_d   = conv_neg;
          deg_d   = conv_deg;
          frac_d  = conv_frac;
          state_d = PUBLISH;
        end else if (expired) begin
          ecnt_d  = sat_inc(ecnt_q);
          state_d = FAULT;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      PUBLISH, FAULT: state_d = WAIT_INTERVAL;
      WAIT_INTERVAL: begin
        if (int_q == INT_LAST) state_d = Enable ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      int_q   <= '0;
      to_q    <= '0;
      msb_q   <= '0;
      ecnt_q  <= '0;
      temp_q  <= '0;
      neg_q   <= 1'b0;
      deg_q   <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      to_q    <= to_d;
      msb_q   <= msb_d;
      ecnt_q  <= ecnt_d;
      temp_q  <= temp_d;
      neg_q   <= neg_d;
      deg_q   <= deg_d;
      frac_q  <= frac_d;
    end
  end

  assign Temperature = temp_q;
  assign Negative    = neg_q;
  assign Degrees     = deg_q;
  assign Fraction    = frac_q;
  assign ErrorCount  = ecnt_q;
  assign TempValid   = (state_q == PUBLISH);
  assign Error       = (state_q == FAULT);

endmodule

// File: tb/tb_temp_read_sequencer.sv
// tb_temp_read_sequencer: table, random and corner-case checks of the temperature read sequencer
`timescale 1ns/1ps
module tb_temp_read_sequencer;

  localparam int SI = 100;
  localparam int TO = 50;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, busy = 1'b0, br = 1'b0;
  logic [7:0] rd = '0;
  logic go, tv, neg, err;
  logic [11:0] temp;
  logic [7:0] deg, ecnt;
  logic [3:0] frac;

  int nvec = 0, nerr = 0, cyc = 0, last_go = 0;
  logic [11:0] m_temp = '0;
  logic [7:0]  m_ecnt = '0;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  l;
    int          d1;
    int          d2;
    logic [11:0] t;
    logic        n;
    logic [7:0]  dg;
    logic [3:0]  fr;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  temp_read_sequencer #(.SampleInterval(SI), .TimeoutCycles(TO)) dut (
    .clock(clk), .Reset(rst_n), .Enable(en), .Busy(busy), .ByteReady(br),
    .ReceivedData(rd), .Go(go), .Temperature(temp), .TempValid(tv),
    .Negative(neg), .Degrees(deg), .Fraction(frac), .Error(err), .ErrorCount(ecnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference conversion from the signed value with plain arithmetic
  function automatic void conv(input logic [11:0] t, output logic n, output logic [7:0] dg,
                               output logic [3:0] fr);
    int v, mag;
    v   = int'(t);
    n   = (v >= 2048);
    mag = n ? 4096 - v : v;
    dg  = 8'(mag / 16);
    fr  = 4'(mag % 16);
  endfunction

  task automatic check_zero(input string p);
    chk({p, "_go"}, go, 0);
    chk({p, "_tempvalid"}, tv, 0);
    chk({p, "_error"}, err, 0);
    chk({p, "_temperature"}, temp, 0);
    chk({p, "_negative"}, neg, 0);
    chk({p, "_degrees"}, deg, 0);
    chk({p, "_fraction"}, frac, 0);
    chk({p, "_errorcount"}, ecnt, 0);
  endtask

  task automatic pulse(input int d, input logic [7:0] b);
    repeat (d) @(negedge clk);
    br = 1'b1;
    rd = b;
    @(negedge clk);
    br = 1'b0;
    rd = 8'($urandom);
  endtask

  task automatic expect_go(input int bound, input int gap);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      #1;
      if (go) found = 1'b1;
      else @(negedge clk);
    end
    chk("go_seen", found, 1);
    if (found) begin
      if (gap > 0) chk("go_gap", cyc - last_go, gap);
      last_go = cyc;
    end
  endtask

  task automatic no_go(input int bound);
    bit saw;
    saw = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (go) saw = 1'b1;
    end
    chk("no_go_while_disabled", saw, 0);
  endtask

  task automatic fault_wait();
    repeat (TO - 1) @(negedge clk);
    chk("error_early", err, 0);
    @(negedge clk);
    m_ecnt = (m_ecnt == 8'hFF) ? 8'hFF : m_ecnt + 8'd1;
    chk("error", err, 1);
    chk("error_count", ecnt, m_ecnt);
    chk("temp_kept", temp, m_temp);
    @(negedge clk);
    chk("error_width", err, 0);
  endtask

  // entered just after Go is seen; bytes are offered d cycles into each wait
  task automatic run_txn(input logic [7:0] m, input logic [7:0] l, input bit miss1, input bit miss2,
                         input int d1, input int d2);
    logic n;
    logic [7:0] dg;
    logic [3:0] fr;
    @(negedge clk);
    chk("go_width", go, 0);
    if (miss1) fault_wait();
    else begin
      pulse(d1, m);
      if (miss2) fault_wait();
      else begin
        pulse(d2, l);
        m_temp = {m, l[7:4]};
        conv(m_temp, n, dg, fr);
        chk("temp_valid", tv, 1);
        chk("temperature", temp, m_temp);
        chk("negative", neg, n);
        chk("degrees", deg, dg);
        chk("fraction", frac, fr);
        chk("errcount_hold", ecnt, m_ecnt);
        @(negedge clk);
        chk("temp_valid_width", tv, 0);
      end
    end
  endtask

  initial begin
    logic [7:0] m, l;
    bit saw;
    tbl[0] = '{8'h19, 8'h00, 0, 0, 12'h190, 1'b0, 8'd25, 4'd0};
    tbl[1] = '{8'hFF, 8'hF0, 3, 5, 12'hFFF, 1'b1, 8'd0, 4'd1};
    tbl[2] = '{8'h80, 8'h00, 10, 1, 12'h800, 1'b1, 8'd128, 4'd0};
    tbl[3] = '{8'h7F, 8'hF0, 0, 20, 12'h7FF, 1'b0, 8'd127, 4'd15};
    tbl[4] = '{8'h00, 8'h10, 2, 2, 12'h001, 1'b0, 8'd0, 4'd1};
    tbl[5] = '{8'hFF, 8'h80, 4, 0, 12'hFF8, 1'b1, 8'd0, 4'd8};
    tbl[6] = '{8'hE6, 8'h70, 1, 3, 12'hE67, 1'b1, 8'd25, 4'd9};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    expect_go(5, 0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) expect_go(150, SI);
      run_txn(tbl[i].m, tbl[i].l, 1'b0, 1'b0, tbl[i].d1, tbl[i].d2);
      chk("tbl_temperature", temp, tbl[i].t);
      chk("tbl_negative", neg, tbl[i].n);
      chk("tbl_degrees", deg, tbl[i].dg);
      chk("tbl_fraction", frac, tbl[i].fr);
    end
    expect_go(150, SI);
    run_txn(8'h12, 8'h34, 1'b1, 1'b0, 0, 0);
    expect_go(150, SI);
    run_txn(8'h12, 8'h34, 1'b0, 1'b1, 7, 0);
    expect_go(150, SI);
    run_txn(8'h05, 8'h80, 1'b0, 1'b0, TO - 1, 0);
    expect_go(150, SI);
    run_txn(8'hFE, 8'h40, 1'b0, 1'b0, 0, TO - 1);
    for (int k = 0; k < 25; k++) begin
      m = 8'($urandom);
      l = 8'($urandom);
      expect_go(150, SI);
      run_txn(m, l, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 40), $urandom_range(0, 40));
    end
    expect_go(150, SI);
    run_txn(8'h19, 8'h00, 1'b0, 1'b0, 1, 1);
    busy = 1'b1;
    saw  = 1'b0;
    while (cyc < last_go + SI + 30) begin
      @(negedge clk);
      #1;
      if (go) saw = 1'b1;
    end
    chk("busy_holds_go", saw, 0);
    busy = 1'b0;
    expect_go(3, SI + 30);
    run_txn(8'h1A, 8'h20, 1'b0, 1'b0, 0, 0);
    expect_go(150, SI);
    en = 1'b0;
    run_txn(8'h2A, 8'h30, 1'b0, 1'b0, 2, 2);
    no_go(150);
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      br = 1'b1;
      rd = 8'($urandom);
      @(negedge clk);
      br = 1'b0;
      #1;
      if (tv || err || go) saw = 1'b1;
    end
    chk("idle_byteready_ignored", saw, 0);
    chk("idle_temp_kept", temp, m_temp);
    en = 1'b1;
    expect_go(3, 0);
    run_txn(8'h03, 8'h20, 1'b0, 1'b0, 0, 0);
    expect_go(150, SI);
    @(negedge clk);
    pulse(3, 8'hAB);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    m_temp = '0;
    m_ecnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_go(3, 0);
    run_txn(8'h01, 8'h50, 1'b0, 1'b0, 1, 1);
    for (int k = 0; k < 300; k++) begin
      expect_go(150, SI);
      run_txn(8'h00, 8'h00, 1'b1, 1'b0, 0, 0);
    end
    chk("errcount_saturated", ecnt, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #3000000;
    nerr++;
    $display("FAIL watchdog: time limit reached, got t=%0t expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog");
  end

endmodule
